// File: rtl/decode_stage_pkg.sv
// Shared constants for the MIPS decode stage: bubble encoding, control bundle
// bit positions and instruction field offsets.
package decode_stage_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h3400_0000;
    localparam int          BUNDLE_W_DEF = 26;
    localparam int          EXT_SEL_BIT  = 19;
    localparam int          RF_WE_BIT    = 0;
    localparam int          RS_LSB       = 21;
    localparam int          RT_LSB       = 16;
    localparam int          RD_LSB       = 11;
    localparam int          IMM_W        = 16;
    localparam int          REG_IDX_W    = 5;
    localparam int          NUM_REGS     = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_sel_e;

    function automatic logic bundle_rf_we(input logic [BUNDLE_W_DEF-1:0] bundle);
        return bundle[RF_WE_BIT];
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback/execute-facing signal bundle of the decode stage.
// The slave modport is the decode stage itself; master is its environment.
interface decode_stage_if #(
    parameter int W        = 32,
    parameter int BUNDLE_W = 26
);
    logic [31:0]         instruction_in;
    logic [BUNDLE_W-1:0] bundle_in;
    logic [W-1:0]        pc_seq_in;
    logic                flush_in;
    logic                ex_mem_re_in;
    logic [4:0]          ex_dst_reg_in;
    logic                wb_we_in;
    logic [4:0]          wb_reg_in;
    logic [W-1:0]        wb_data_in;

    logic                stall_out;
    logic                valid_out;
    logic [31:0]         instruction_out;
    logic [BUNDLE_W-1:0] bundle_out;
    logic [W-1:0]        pc_seq_out;
    logic [W-1:0]        rs_data_out;
    logic [W-1:0]        rt_data_out;
    logic [4:0]          rs_idx_out;
    logic [4:0]          rt_idx_out;
    logic [4:0]          rd_idx_out;
    logic [W-1:0]        imm_ext_out;

    modport master (
        output instruction_in, bundle_in, pc_seq_in, flush_in,
               ex_mem_re_in, ex_dst_reg_in, wb_we_in, wb_reg_in, wb_data_in,
        input  stall_out, valid_out, instruction_out, bundle_out, pc_seq_out,
               rs_data_out, rt_data_out, rs_idx_out, rt_idx_out, rd_idx_out,
               imm_ext_out
    );

    modport slave (
        input  instruction_in, bundle_in, pc_seq_in, flush_in,
               ex_mem_re_in, ex_dst_reg_in, wb_we_in, wb_reg_in, wb_data_in,
        output stall_out, valid_out, instruction_out, bundle_out, pc_seq_out,
               rs_data_out, rt_data_out, rs_idx_out, rt_idx_out, rd_idx_out,
               imm_ext_out
    );
endinterface

// File: rtl/decode_stage_reg_file_2r1w.sv
// Architectural register file: 32 x W, two combinational read ports with
// write-through from the writeback port, r0 hardwired to zero.
module reg_file_2r1w
    import decode_stage_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  reg_idx_t     i_waddr,
    input  logic [W-1:0] i_wdata,
    input  reg_idx_t     i_raddr_a,
    input  reg_idx_t     i_raddr_b,
    output logic [W-1:0] o_rdata_a,
    output logic [W-1:0] o_rdata_b
);

    logic [W-1:0] r_mem [NUM_REGS];
    logic         w_hit_a;
    logic         w_hit_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A same-cycle writeback to the index being read wins over the stored value.
    assign w_hit_a = i_we && (i_waddr == i_raddr_a);
    assign w_hit_b = i_we && (i_waddr == i_raddr_b);

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : (w_hit_a ? i_wdata : r_mem[i_raddr_a]);
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : (w_hit_b ? i_wdata : r_mem[i_raddr_b]);

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file read, immediate
// extension, load-use hazard detection and the registered ID/EX bundle.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int          W        = 32,
    parameter int          BUNDLE_W = 26,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic         clk,
    input  logic         reset,
    decode_stage_if.slave bus
);

    function automatic logic [W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                input logic             zero_ext);
        logic signed [W-1:0] sext;
        sext = {{(W-IMM_W){imm[IMM_W-1]}}, imm};
        return zero_ext ? {{(W-IMM_W){1'b0}}, imm} : sext;
    endfunction

    logic [31:0]         r_instr_p0;
    logic [BUNDLE_W-1:0] r_bundle_p0;
    logic [W-1:0]        r_pc_p0;
    logic                r_vld_p0;

    logic [31:0]         r_instr_p1;
    logic [BUNDLE_W-1:0] r_bundle_p1;
    logic [W-1:0]        r_pc_p1;
    reg_idx_t            r_rs_idx_p1;
    reg_idx_t            r_rt_idx_p1;
    reg_idx_t            r_rd_idx_p1;
    logic [W-1:0]        r_rs_data_p1;
    logic [W-1:0]        r_rt_data_p1;
    logic [W-1:0]        r_imm_p1;
    logic                r_vld_p1;

    reg_idx_t            w_rs_idx;
    reg_idx_t            w_rt_idx;
    reg_idx_t            w_rd_idx;
    logic [W-1:0]        w_rs_data;
    logic [W-1:0]        w_rt_data;
    logic [W-1:0]        w_imm_ext;
    ext_sel_e            w_ext_sel;
    logic                w_stall;

    // IF/ID boundary (p0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_p0  <= NOP;
            r_bundle_p0 <= '0;
            r_pc_p0     <= '0;
            r_vld_p0    <= 1'b0;
        end else if (bus.flush_in) begin
            r_instr_p0  <= NOP;
            r_bundle_p0 <= '0;
            r_pc_p0     <= '0;
            r_vld_p0    <= 1'b0;
        end else if (!w_stall) begin
            r_instr_p0  <= bus.instruction_in;
            r_bundle_p0 <= bus.bundle_in;
            r_pc_p0     <= bus.pc_seq_in;
            r_vld_p0    <= 1'b1;
        end
    end

    assign w_rs_idx  = r_instr_p0[RS_LSB +: REG_IDX_W];
    assign w_rt_idx  = r_instr_p0[RT_LSB +: REG_IDX_W];
    assign w_rd_idx  = r_instr_p0[RD_LSB +: REG_IDX_W];
    assign w_ext_sel = ext_sel_e'(r_bundle_p0[EXT_SEL_BIT]);
    assign w_imm_ext = extend_imm(r_instr_p0[IMM_W-1:0], w_ext_sel == EXT_ZERO);

    // rt is compared even for I-type instructions where it is a destination.
    assign w_stall = r_vld_p0 & bus.ex_mem_re_in & (bus.ex_dst_reg_in != '0)
                   & ((bus.ex_dst_reg_in == w_rs_idx) | (bus.ex_dst_reg_in == w_rt_idx));

    reg_file_2r1w #(.W(W)) u_rf (
        .clk       (clk),
        .rst       (reset),
        .i_we      (bus.wb_we_in),
        .i_waddr   (bus.wb_reg_in),
        .i_wdata   (bus.wb_data_in),
        .i_raddr_a (w_rs_idx),
        .i_raddr_b (w_rt_idx),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data)
    );

    // ID/EX boundary (p1)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_p1   <= NOP;
            r_bundle_p1  <= '0;
            r_pc_p1      <= '0;
            r_rs_idx_p1  <= '0;
            r_rt_idx_p1  <= '0;
            r_rd_idx_p1  <= '0;
            r_rs_data_p1 <= '0;
            r_rt_data_p1 <= '0;
            r_imm_p1     <= '0;
            r_vld_p1     <= 1'b0;
        end else if (bus.flush_in || w_stall) begin
            r_instr_p1   <= NOP;
            r_bundle_p1  <= '0;
            r_pc_p1      <= '0;
            r_rs_idx_p1  <= '0;
            r_rt_idx_p1  <= '0;
            r_rd_idx_p1  <= '0;
            r_rs_data_p1 <= '0;
            r_rt_data_p1 <= '0;
            r_imm_p1     <= '0;
            r_vld_p1     <= 1'b0;
        end else begin
            r_instr_p1   <= r_instr_p0;
            r_bundle_p1  <= r_bundle_p0;
            r_pc_p1      <= r_pc_p0;
            r_rs_idx_p1  <= w_rs_idx;
            r_rt_idx_p1  <= w_rt_idx;
            r_rd_idx_p1  <= w_rd_idx;
            r_rs_data_p1 <= w_rs_data;
            r_rt_data_p1 <= w_rt_data;
            r_imm_p1     <= w_imm_ext;
            r_vld_p1     <= r_vld_p0;
        end
    end

    assign bus.stall_out       = w_stall;
    assign bus.valid_out       = r_vld_p1;
    assign bus.instruction_out = r_instr_p1;
    assign bus.bundle_out      = r_bundle_p1;
    assign bus.pc_seq_out      = r_pc_p1;
    assign bus.rs_idx_out      = r_rs_idx_p1;
    assign bus.rt_idx_out      = r_rt_idx_p1;
    assign bus.rd_idx_out      = r_rd_idx_p1;
    assign bus.rs_data_out     = r_rs_data_p1;
    assign bus.rt_data_out     = r_rt_data_p1;
    assign bus.imm_ext_out     = r_imm_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed fetch vectors push expected
// ID/EX bundles; a negedge monitor pops and compares each valid output.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [25:0] bundle;
        logic [31:0] pc;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    localparam logic [31:0] BUBBLE = 32'h3400_0000;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t q[$];
    exp_t mon_e;

    decode_stage_if #(.W(32), .BUNDLE_W(26)) bus ();

    decode_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        chk({pfx, ".valid"},  {31'b0, bus.valid_out},       32'h0);
        chk({pfx, ".instr"},  bus.instruction_out,          BUBBLE);
        chk({pfx, ".bundle"}, {6'b0, bus.bundle_out},       32'h0);
        chk({pfx, ".pc"},     bus.pc_seq_out,               32'h0);
        chk({pfx, ".rsdata"}, bus.rs_data_out,              32'h0);
        chk({pfx, ".rtdata"}, bus.rt_data_out,              32'h0);
        chk({pfx, ".idx"},    {17'b0, bus.rs_idx_out, bus.rt_idx_out, bus.rd_idx_out}, 32'h0);
        chk({pfx, ".imm"},    bus.imm_ext_out,              32'h0);
        chk({pfx, ".stall"},  {31'b0, bus.stall_out},       32'h0);
    endtask

    task automatic set_wb(input logic [4:0] idx, input logic [31:0] data);
        bus.wb_we_in   = 1'b1;
        bus.wb_reg_in  = idx;
        bus.wb_data_in = data;
    endtask

    // Present one fetch; push the expected ID/EX bundle if it will issue.
    task automatic step(input logic [31:0] instr, input logic [25:0] bun,
                        input logic [31:0] pc, input bit push,
                        input logic [31:0] e_rs, input logic [31:0] e_rt,
                        input logic [31:0] e_imm, input logic e_stall);
        exp_t e;
        bus.instruction_in = instr;
        bus.bundle_in      = bun;
        bus.pc_seq_in      = pc;
        if (push) begin
            e.instr  = instr;
            e.bundle = bun;
            e.pc     = pc;
            e.rs_d   = e_rs;
            e.rt_d   = e_rt;
            e.imm    = e_imm;
            e.rs     = instr[25:21];
            e.rt     = instr[20:16];
            e.rd     = instr[15:11];
            q.push_back(e);
        end
        #1;
        chk("stall_out", {31'b0, bus.stall_out}, {31'b0, e_stall});
        @(posedge clk);
        #1;
        bus.wb_we_in   = 1'b0;
        bus.wb_reg_in  = '0;
        bus.wb_data_in = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.valid_out) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got instr %h, required no valid output",
                         bus.instruction_out);
            end else begin
                mon_e = q.pop_front();
                chk("issue.instr",  bus.instruction_out,  mon_e.instr);
                chk("issue.bundle", {6'b0, bus.bundle_out}, {6'b0, mon_e.bundle});
                chk("issue.pc",     bus.pc_seq_out,       mon_e.pc);
                chk("issue.rsidx",  {27'b0, bus.rs_idx_out}, {27'b0, mon_e.rs});
                chk("issue.rtidx",  {27'b0, bus.rt_idx_out}, {27'b0, mon_e.rt});
                chk("issue.rdidx",  {27'b0, bus.rd_idx_out}, {27'b0, mon_e.rd});
                chk("issue.rsdata", bus.rs_data_out,      mon_e.rs_d);
                chk("issue.rtdata", bus.rt_data_out,      mon_e.rt_d);
                chk("issue.imm",    bus.imm_ext_out,      mon_e.imm);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] instr;
        errors = 0;
        checks = 0;
        bus.instruction_in = '0;
        bus.bundle_in      = '0;
        bus.pc_seq_in      = '0;
        bus.flush_in       = 1'b0;
        bus.ex_mem_re_in   = 1'b0;
        bus.ex_dst_reg_in  = '0;
        bus.wb_we_in       = 1'b0;
        bus.wb_reg_in      = '0;
        bus.wb_data_in     = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 check_idle("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // register loads and reads, including same-cycle write-through
        set_wb(5'd5, 32'h1234_5678);
        step(BUBBLE,       26'h0, 32'h04, 1, 32'h0, 32'h0, 32'h0, 1'b0);
        step(32'h00A9_5020, 26'h0, 32'h08, 1, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0000_5020, 1'b0);
        set_wb(5'd9, 32'hA5A5_A5A5);
        step(BUBBLE,       26'h0, 32'h0C, 1, 32'h0, 32'h0, 32'h0, 1'b0);
        step(32'h2008_0005, 26'h1, 32'h10, 1, 32'h0, 32'h0, 32'h0000_0005, 1'b0);
        step(32'h0100_0000, 26'h0, 32'h14, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
        set_wb(5'd8, 32'hDEAD_BEEF);
        step(32'h0100_0000, 26'h0, 32'h18, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
        set_wb(5'd0, 32'hFFFF_FFFF);
        step(BUBBLE,       26'h0, 32'h1C, 1, 32'h0, 32'h0, 32'h0, 1'b0);

        // immediate extension select
        step(32'h2008_8000, 26'h0,      32'h20, 1, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_8000, 1'b0);
        step(32'h3008_8000, 26'h8_0000, 32'h24, 1, 32'h0, 32'hDEAD_BEEF, 32'h0000_8000, 1'b0);

        // load-use on rs=9: one bubble, IF/ID held, then both issue in order
        step(32'h0120_4020, 26'h0, 32'h28, 1, 32'hA5A5_A5A5, 32'h0, 32'h0000_4020, 1'b0);
        bus.ex_mem_re_in  = 1'b1;
        bus.ex_dst_reg_in = 5'd9;
        step(32'h2009_0007, 26'h1, 32'h2C, 0, 32'h0, 32'h0, 32'h0, 1'b1);
        bus.ex_mem_re_in  = 1'b0;
        bus.ex_dst_reg_in = 5'd0;
        #1;
        chk("stall.bubble_valid", {31'b0, bus.valid_out}, 32'h0);
        chk("stall.cleared",      {31'b0, bus.stall_out}, 32'h0);
        step(32'h2009_0007, 26'h1, 32'h2C, 1, 32'h0, 32'hA5A5_A5A5, 32'h0000_0007, 1'b0);

        // load to r0 never stalls even though the decoded rs is 0
        bus.ex_mem_re_in  = 1'b1;
        bus.ex_dst_reg_in = 5'd0;
        step(BUBBLE,       26'h0, 32'h30, 1, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.ex_mem_re_in  = 1'b0;

        // flush coinciding with a load-use stall
        step(32'h0120_4020, 26'h0, 32'h34, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.flush_in      = 1'b1;
        bus.ex_mem_re_in  = 1'b1;
        bus.ex_dst_reg_in = 5'd9;
        step(BUBBLE,       26'h0, 32'h38, 0, 32'h0, 32'h0, 32'h0, 1'b1);
        bus.flush_in = 1'b0;
        #1;
        chk("flush.stall_dropped", {31'b0, bus.stall_out}, 32'h0);
        chk("flush.bubble_valid",  {31'b0, bus.valid_out}, 32'h0);
        step(32'h2008_0005, 26'h1, 32'h3C, 1, 32'h0, 32'hDEAD_BEEF, 32'h0000_0005, 1'b0);
        bus.ex_mem_re_in  = 1'b0;
        bus.ex_dst_reg_in = 5'd0;
        step(BUBBLE,       26'h0, 32'h40, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.flush_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush_in = 1'b0;

        // asynchronous reset with instructions in flight
        step(32'h0120_4020, 26'h0, 32'h44, 1, 32'hA5A5_A5A5, 32'h0, 32'h0000_4020, 1'b0);
        step(BUBBLE,       26'h0, 32'h48, 1, 32'h0, 32'h0, 32'h0, 1'b0);
        #1 reset = 1'b1;
        #1 check_idle("midreset");
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        // every register reads zero after reset
        for (int k = 0; k < 16; k++) begin
            instr = {6'd0, 5'(2 * k), 5'(2 * k + 1), 16'h0000};
            step(instr, 26'h0, 32'h100 + 32'(4 * k), 1, 32'h0, 32'h0, 32'h0, 1'b0);
        end
        step(BUBBLE, 26'h0, 32'h200, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.flush_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
